// File: rtl/rom_map_pkg.sv
// DigDug ROM download layout and load-sequencer state encoding.
package rom_map_pkg;

  localparam int MAP_NREG = 8;
  localparam int MAP_AW   = 25;

  // Region order: CPU0, CPU1, CPU2, fg gfx, bg gfx, sprite gfx, palette/lookup PROMs, sound PROM
  localparam logic [MAP_NREG-1:0][MAP_AW-1:0] REG_BASE = {
    25'h0_8A20,  // sound PROM
    25'h0_8800,  // palette + lookup PROMs
    25'h0_7800,  // sprite gfx
    25'h0_6800,  // bg gfx
    25'h0_6000,  // fg gfx
    25'h0_5000,  // CPU2
    25'h0_4000,  // CPU1
    25'h0_0000   // CPU0
  };

  localparam logic [MAP_AW-1:0] TOTAL_BYTES = 25'h0_8B20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/rom_region_dec.sv
// Registered download-address decoder: one-hot region strobe plus region-relative offset.
module rom_region_dec
  import rom_map_pkg::*;
#(
  parameter int NREG   = 8,
  parameter int ADDR_W = 25,
  parameter int OFS_W  = 16
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [NREG-1:0]   wr_oh,
  output logic [OFS_W-1:0]  ofs
);

  localparam int SEL_W = (NREG > 1) ? $clog2(NREG) : 1;

  logic [SEL_W-1:0] sel;

  // Bases ascend, so the last base not above addr is the owning region.
  always_comb begin
    sel = '0;
    for (int i = 1; i < NREG; i++)
      if (addr >= ADDR_W'(REG_BASE[i])) sel = SEL_W'(i);
  end

  assign hit = (addr < ADDR_W'(TOTAL_BYTES));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_oh <= '0;
      ofs   <= '0;
    end else begin
      wr_oh <= '0;
      if (wr_en && hit) begin
        wr_oh[sel] <= 1'b1;
        ofs        <= OFS_W'(addr - ADDR_W'(REG_BASE[sel]));
      end
    end
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// HPS ROM download sequencer for the DigDug core: region strobes, order/length check, core reset hold.
// Optional ROM_CKSUM_EN builds an additive checksum of written bytes; otherwise cksum is tied low.
module rom_load_ctrl
  import rom_map_pkg::*;
#(
  parameter int NREG     = 8,
  parameter int ADDR_W   = 25,
  parameter int OFS_W    = 16,
  parameter int HOLD_CYC = 1024
) (
  input  logic              clk_sys,
  input  logic              RESET_N,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic [NREG-1:0]   rom_wr,
  output logic [OFS_W-1:0]  rom_addr,
  output logic [7:0]        rom_data,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       cksum
);

  localparam int CNT_W = 17;
  localparam int HC_W  = $clog2(HOLD_CYC + 1);

  ld_state_e        state_q, state_d;
  logic [CNT_W-1:0] byte_cnt;
  logic [HC_W-1:0]  hold_cnt;
  logic             err_q;
  logic             enter, accept, hit, hold_end, img_ok;

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (dl_active && state_q != ST_LOAD) state_d = ST_LOAD;
    else begin
      case (state_q)
        ST_LOAD: if (!dl_active) state_d = ST_HOLD;
        ST_HOLD: if (hold_end)   state_d = img_ok ? ST_RUN : ST_IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    enter    = dl_active && (state_q != ST_LOAD);
    accept   = (state_q == ST_LOAD) && dl_wr;
    hold_end = (state_q == ST_HOLD) && (hold_cnt == HC_W'(HOLD_CYC - 1));
    img_ok   = !err_q && (MAP_AW'(byte_cnt) == TOTAL_BYTES);
  end

  rom_region_dec #(
    .NREG   (NREG),
    .ADDR_W (ADDR_W),
    .OFS_W  (OFS_W)
  ) u_dec (
    .clk_sys (clk_sys),
    .rst_n   (RESET_N),
    .wr_en   (accept),
    .addr    (dl_addr),
    .hit     (hit),
    .wr_oh   (rom_wr),
    .ofs     (rom_addr)
  );

  // core_rst follows the next state so it rises on the same edge LOAD is registered.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      byte_cnt  <= '0;
      hold_cnt  <= '0;
      err_q     <= 1'b0;
      rom_data  <= '0;
      core_rst  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      core_rst <= (state_d != ST_RUN);
      if (enter) begin
        byte_cnt  <= '0;
        hold_cnt  <= '0;
        err_q     <= 1'b0;
        load_done <= 1'b0;
        load_err  <= 1'b0;
      end else begin
        if (accept) begin
          if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
          if (!hit || dl_addr != ADDR_W'(byte_cnt)) err_q <= 1'b1;
          if (hit) rom_data <= dl_data;
        end
        if (state_q == ST_HOLD) hold_cnt <= hold_cnt + 1'b1;
        if (state_q == ST_HOLD && state_d == ST_RUN)  load_done <= 1'b1;
        if (state_q == ST_HOLD && state_d == ST_IDLE) load_err  <= 1'b1;
      end
    end
  end

`ifdef ROM_CKSUM_EN
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N)          cksum <= '0;
    else if (enter)        cksum <= '0;
    else if (accept && hit) cksum <= cksum + {8'h00, dl_data};
  end
`else
  assign cksum = 16'h0000;
`endif

endmodule
